// File: rtl/log2_share_arbiter.sv
// Round-robin front end that shares one in-order log2 core among N_REQ requesters.
// Requester IDs ride alongside the core in a tag FIFO and are reattached to results.

module log2_share_lane #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int LANE  = 0
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  ptr,
  output logic             gnt
);
  // A lane wins when it is valid and no valid lane sits closer to ptr in RR order.
  always_comb begin
    int d_self;
    int d_j;
    d_self = (LANE + N_REQ - int'(ptr)) % N_REQ;
    gnt    = req_valid[LANE];
    for (int j = 0; j < N_REQ; j++) begin
      d_j = (j + N_REQ - int'(ptr)) % N_REQ;
      if (j != LANE && req_valid[j] && d_j < d_self) gnt = 1'b0;
    end
  end
endmodule

module log2_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int LOG2_W    = 20,
  parameter int TAG_DEPTH = 8,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       core_data_o,
  output logic                    core_valid_o,
  input  logic [LOG2_W-1:0]       core_log2_i,
  input  logic                    core_valid_i,
  output logic [LOG2_W-1:0]       res_log2_o,
  output logic [ID_W-1:0]         res_id_o,
  output logic                    res_valid_o,
  output logic                    err_o
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic [ID_W-1:0]   ptr;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [DATA_W-1:0] sel_data;

  logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              not_full, empty, accept, push, pop;

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    log2_share_lane #(.N_REQ(N_REQ), .ID_W(ID_W), .LANE(k)) u_lane (
      .req_valid (req_valid_i),
      .ptr       (ptr),
      .gnt       (gnt[k])
    );
  end

  always_comb begin
    gnt_id   = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        gnt_id   = ID_W'(k);
        sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign not_full    = count < CW'(TAG_DEPTH);
  assign empty       = count == '0;
  assign req_ready_o = not_full ? gnt : '0;
  assign accept      = |(req_valid_i & req_ready_o);
  assign push        = accept;
  // An orphan result (FIFO empty) is flagged, never popped.
  assign pop         = core_valid_i & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      core_valid_o <= 1'b0;
      res_valid_o  <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      core_valid_o <= accept;
      res_valid_o  <= pop;
      if (core_valid_i && empty) err_o <= 1'b1;
      if (accept) ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload registers carry no reset; they are qualified by their valids.
  always_ff @(posedge clock) begin
    if (accept) core_data_o <= sel_data;
    if (push)   tag_mem[wr_ptr] <= gnt_id;
    if (pop) begin
      res_log2_o <= core_log2_i;
      res_id_o   <= tag_mem[rd_ptr];
    end
  end
endmodule
